regfile_access_arbiter: RTL and testbench
=========================================

REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 32, gives the register count; 16 selects the RV32E variant.
REQ-002 Parameter REG_BASE, default 32'h4100, is the bus address of x0; register n sits at REG_BASE+4n.
REQ-003 Parameter DRAIN_LIMIT, default 255, is the maximum number of cycles to wait for core drain.
REQ-004 Port clk, input, 1, is the single clock, rising edge.
REQ-005 Port reset, input, 1, is the reset: asynchronous, active-low.
REQ-006 Ports wb_valid (1), wb_reg (5) and wb_data (32) are inputs carrying core writeback requests.
REQ-007 Port core_stall, output, 1, stalls the core pipeline.
REQ-008 Port core_idle, input, 1, is high when the core has no in-flight instructions.
REQ-009 Ports slv_address (32), slv_write_data (32), slv_mode (2: 01 read, 10 write) and slv_select_regs (1) are inputs from the debug bus slave.
REQ-010 Ports slv_ready (1), slv_read_data (32) and slv_error (1) are outputs, the debug bus response.
REQ-011 Ports rf_write_reg (5), rf_write_data (32) and rf_cs_reg_write (1) are outputs driving the register file write port.
REQ-012 Port rf_read_reg, output, 5, drives register file read port 1 during debug reads.
REQ-013 Port rf_read_data, input, 32, is register file read data port 1.

Function
REQ-014 The FSM has four states: IDLE, DRAIN, ACCESS and RESPOND.
REQ-015 Armed flag: set when slv_select_regs is low at a clock edge; cleared on leaving IDLE.
REQ-016 Request acceptance: IDLE with armed && slv_select_regs && slv_mode in {01,10} latches address, data and mode.
REQ-017 Decode: index = (addr-REG_BASE)>>2; the address is valid when addr[1:0]==0, addr>=REG_BASE and index<NUM_REGS.
REQ-018 An invalid address goes IDLE->RESPOND, with slv_error=1, slv_read_data=0, and no register-file or stall activity.
REQ-019 A valid address goes IDLE->DRAIN, and core_stall=1 from the DRAIN entry cycle until RESPOND exits.
REQ-020 DRAIN: the core writeback passes through (rf_* = wb_*); when core_idle && !wb_valid, go to ACCESS.
REQ-021 DRAIN timeout: the 8-bit counter is cleared on entry; on reaching DRAIN_LIMIT, go to RESPOND with slv_error=1 and do no access.
REQ-022 ACCESS write (one cycle): rf_cs_reg_write=1, rf_write_reg=index, rf_write_data=latched data; index 0 suppresses rf_cs_reg_write.
REQ-023 ACCESS read (one cycle): rf_read_reg=index; rf_read_data is registered into slv_read_data at the end of the cycle.
REQ-024 ACCESS always goes to RESPOND after one cycle.
REQ-025 ACCESS conflict: if wb_valid is high in ACCESS, debug wins, the core write is dropped and slv_error=1.
REQ-026 RESPOND: slv_ready=1 for exactly one cycle, then go to IDLE; slv_read_data and slv_error hold until the next acceptance.
REQ-027 IDLE passthrough: rf_* mirror wb_* combinationally, giving zero added latency on the core path.
REQ-028 Debug access latency: a valid write with core already idle gives slv_ready 3 cycles after acceptance.
REQ-029 Modes 00 and 11 are ignored in every state.
REQ-030 Changes to slv_* inputs after acceptance have no effect.

Reset
REQ-031 Reset low asynchronously forces state IDLE, armed=0, counter=0, core_stall=0, slv_ready=0, slv_error=0, slv_read_data=0, rf_cs_reg_write=0 and rf_read_reg=0.
REQ-032 Reset mid-operation abandons the access, with no register-file write issued after reset asserts.

Structure
REQ-033 The shared package holds: the state encoding, the slv_mode encodings, the REG_BASE default and the DRAIN_LIMIT default.
REQ-034 The address check is a sub-module, regfile_addr_decode (address in; index and valid out), reusable by other debug-mapped blocks.

Verification
REQ-035 Core idle, debug write 0x4114 data 0xDEADBEEF: rf write to x5 in ACCESS, slv_ready at cycle +3, x5 reads 0xDEADBEEF.
REQ-036 Debug read 0x4100 after a write of x0: no rf write issued, slv_read_data=0, slv_error=0.
REQ-037 Address 0x4102 and address 0x4180: slv_error=1, core_stall never asserted, slv_ready one cycle after acceptance.
REQ-038 core_idle held low for 300 cycles: slv_error=1 with slv_ready after 255 DRAIN cycles, then core_stall returns to 0.
REQ-039 wb_valid pulses during DRAIN write x7=0x11: the core write lands, then the debug access completes.
REQ-040 Select held high across RESPOND: no second access until select drops for a cycle.
REQ-041 Reset pulsed during DRAIN: all outputs return to reset values and no write occurs.
REQ-042 NUM_REGS=16, address 0x4140: slv_error=1.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared definitions for the debug register-file access arbiter: FSM state
// encoding, debug bus mode encodings and the default parameter values.
package regfile_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam logic [1:0]  MODE_READ           = 2'b01;
    localparam logic [1:0]  MODE_WRITE          = 2'b10;
    localparam logic [31:0] REG_BASE_DEFAULT    = 32'h0000_4100;
    localparam int          DRAIN_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/regfile_access_arbiter_addr_decode.sv
// Maps a debug bus address onto a register index and flags whether it hits
// a word-aligned register inside the window.
module regfile_addr_decode
    import regfile_access_arbiter_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] REG_BASE = REG_BASE_DEFAULT
) (
    input  logic [31:0] addr,
    output logic [4:0]  index,
    output logic        valid
);

    logic [29:0] word;

    // Word offset from the base; equals (addr - REG_BASE) >> 2 for aligned addresses.
    assign word  = addr[31:2] - REG_BASE[31:2];
    assign index = word[4:0];
    assign valid = (addr[1:0] == 2'b00) && (addr >= REG_BASE) && (word < 30'(NUM_REGS));

endmodule

// File: rtl/regfile_access_arbiter.sv
// Arbitrates register-file access between core writeback and the debug bus:
// stalls and drains the core, performs one debug read/write, then responds.
module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter int          NUM_REGS    = 32,
    parameter logic [31:0] REG_BASE    = REG_BASE_DEFAULT,
    parameter int          DRAIN_LIMIT = DRAIN_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        core_stall,
    input  logic        core_idle,
    input  logic [31:0] slv_address,
    input  logic [31:0] slv_write_data,
    input  logic [1:0]  slv_mode,
    input  logic        slv_select_regs,
    output logic        slv_ready,
    output logic [31:0] slv_read_data,
    output logic        slv_error,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        rf_cs_reg_write,
    output logic [4:0]  rf_read_reg,
    input  logic [31:0] rf_read_data
);

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_write_q, is_write_d;
    logic        core_stall_q, core_stall_d;
    logic        slv_ready_q, slv_ready_d;
    logic        slv_error_q, slv_error_d;
    logic [31:0] rdata_q, rdata_d;

    logic [4:0]  dec_index;
    logic        dec_valid;
    logic        accept;

    regfile_addr_decode #(
        .NUM_REGS (NUM_REGS),
        .REG_BASE (REG_BASE)
    ) u_decode (
        .addr  (slv_address),
        .index (dec_index),
        .valid (dec_valid)
    );

    assign accept = (state_q == ST_IDLE) && armed_q && slv_select_regs &&
                    ((slv_mode == MODE_READ) || (slv_mode == MODE_WRITE));

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | ~slv_select_regs;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        core_stall_d = core_stall_q;
        slv_ready_d  = 1'b0;
        slv_error_d  = slv_error_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    armed_d     = 1'b0;
                    idx_d       = dec_index;
                    wdata_d     = slv_write_data;
                    is_write_d  = (slv_mode == MODE_WRITE);
                    cnt_d       = 8'd0;
                    rdata_d     = 32'd0;
                    slv_error_d = 1'b0;
                    if (dec_valid) begin
                        state_d      = ST_DRAIN;
                        core_stall_d = 1'b1;
                    end else begin
                        state_d     = ST_RESPOND;
                        slv_error_d = 1'b1;
                        slv_ready_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (core_idle && !wb_valid) begin
                    state_d = ST_ACCESS;
                end else if (({1'b0, cnt_q} + 9'd1) >= 9'(DRAIN_LIMIT)) begin
                    state_d     = ST_RESPOND;
                    slv_error_d = 1'b1;
                    slv_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESPOND;
                slv_ready_d = 1'b1;
                slv_error_d = wb_valid;
                if (!is_write_q) begin
                    rdata_d = rf_read_data;
                end
            end
            ST_RESPOND: begin
                state_d      = ST_IDLE;
                core_stall_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            cnt_q        <= 8'd0;
            idx_q        <= 5'd0;
            wdata_q      <= 32'd0;
            is_write_q   <= 1'b0;
            core_stall_q <= 1'b0;
            slv_ready_q  <= 1'b0;
            slv_error_q  <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            core_stall_q <= core_stall_d;
            slv_ready_q  <= slv_ready_d;
            slv_error_q  <= slv_error_d;
            rdata_q      <= rdata_d;
        end
    end

    // Core writeback passes straight through except in ACCESS, where the debug
    // port owns the write port and any concurrent core write is dropped.
    always_comb begin
        rf_write_reg    = wb_reg;
        rf_write_data   = wb_data;
        rf_cs_reg_write = wb_valid & reset;
        rf_read_reg     = 5'd0;
        if (state_q == ST_ACCESS) begin
            rf_write_reg    = idx_q;
            rf_write_data   = wdata_q;
            rf_cs_reg_write = is_write_q && (idx_q != 5'd0);
            if (!is_write_q) begin
                rf_read_reg = idx_q;
            end
        end
    end

    assign core_stall    = core_stall_q;
    assign slv_ready     = slv_ready_q;
    assign slv_error     = slv_error_q;
    assign slv_read_data = rdata_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: a vector table of debug accesses
// plus hand-written sequences for drain, timeout, reselect, mode and reset cases.
module tb_regfile_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        core_idle;
    logic [31:0] slv_address;
    logic [31:0] slv_write_data;
    logic [1:0]  slv_mode;
    logic        slv_select_regs;

    logic        core_stall, slv_ready, slv_error, rf_cs_reg_write;
    logic [31:0] slv_read_data, rf_write_data, rf_read_data;
    logic [4:0]  rf_write_reg, rf_read_reg;

    logic        d16_core_stall, d16_slv_ready, d16_slv_error, d16_rf_cs;
    logic [31:0] d16_slv_read_data, d16_rf_write_data;
    logic [31:0] d16_rf_read_data = 32'd0;
    logic [4:0]  d16_rf_write_reg, d16_rf_read_reg;

    logic [31:0] regs [32] = '{default: 32'd0};
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_access_arbiter dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .core_stall(core_stall), .core_idle(core_idle),
        .slv_address(slv_address), .slv_write_data(slv_write_data),
        .slv_mode(slv_mode), .slv_select_regs(slv_select_regs),
        .slv_ready(slv_ready), .slv_read_data(slv_read_data), .slv_error(slv_error),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_cs_reg_write(rf_cs_reg_write), .rf_read_reg(rf_read_reg),
        .rf_read_data(rf_read_data)
    );

    regfile_access_arbiter #(.NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .core_stall(d16_core_stall), .core_idle(core_idle),
        .slv_address(slv_address), .slv_write_data(slv_write_data),
        .slv_mode(slv_mode), .slv_select_regs(slv_select_regs),
        .slv_ready(d16_slv_ready), .slv_read_data(d16_slv_read_data), .slv_error(d16_slv_error),
        .rf_write_reg(d16_rf_write_reg), .rf_write_data(d16_rf_write_data),
        .rf_cs_reg_write(d16_rf_cs), .rf_read_reg(d16_rf_read_reg),
        .rf_read_data(d16_rf_read_data)
    );

    // External register file: x0 hardwired to zero.
    assign rf_read_data = regs[rf_read_reg];
    always @(posedge clk) begin
        if (rf_cs_reg_write) begin
            wr_count <= wr_count + 1;
            if (rf_write_reg != 5'd0) regs[rf_write_reg] <= rf_write_data;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_writes;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Select low for one edge to arm, then present the request; it is accepted
    // at the following rising edge.
    task automatic start_access(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        slv_select_regs = 1'b0;
        slv_mode        = 2'b00;
        @(negedge clk);
        slv_select_regs = 1'b1;
        slv_mode        = wr ? 2'b10 : 2'b01;
        slv_address     = addr;
        slv_write_data  = data;
    endtask

    task automatic wait_ready(output int n, output bit stall_seen);
        n = 0;
        stall_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            stall_seen |= core_stall;
            if (n == 1) begin
                slv_address    = 32'h0000_4104;
                slv_write_data = 32'h0BAD_0BAD;
            end
        end while (!slv_ready && n < 400);
        chk("ready_seen", {31'd0, slv_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit st;
        int w0;
        w0 = wr_count;
        start_access(v.wr, v.addr, v.data);
        wait_ready(n, st);
        chk("latency", n, v.exp_lat);
        chk("slv_error", {31'd0, slv_error}, {31'd0, v.exp_err});
        chk("slv_read_data", slv_read_data, v.exp_rdata);
        chk("stall_seen", {31'd0, st}, (v.exp_lat > 1) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'd0, slv_ready}, 32'd0);
        chk("stall_released", {31'd0, core_stall}, 32'd0);
        chk("rf_writes", wr_count - w0, v.exp_writes);
        $display("access wr=%0b addr=%h data=%h -> lat=%0d err=%0b rdata=%h",
                 v.wr, v.addr, v.data, n, slv_error, slv_read_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        bit st, bad;
        int w0;
        vec_t tv;

        vecs[0] = '{1'b1, 32'h0000_4114, 32'hDEAD_BEEF, 1'b0, 32'h0,          3, 1};
        vecs[1] = '{1'b0, 32'h0000_4114, 32'h0,         1'b0, 32'hDEAD_BEEF, 3, 0};
        vecs[2] = '{1'b1, 32'h0000_4100, 32'h1234_5678, 1'b0, 32'h0,          3, 0};
        vecs[3] = '{1'b0, 32'h0000_4100, 32'h0,         1'b0, 32'h0,          3, 0};
        vecs[4] = '{1'b1, 32'h0000_4102, 32'h5555_5555, 1'b1, 32'h0,          1, 0};
        vecs[5] = '{1'b0, 32'h0000_4180, 32'h0,         1'b1, 32'h0,          1, 0};
        vecs[6] = '{1'b0, 32'h0000_40FC, 32'h0,         1'b1, 32'h0,          1, 0};
        vecs[7] = '{1'b1, 32'h0000_417C, 32'hA5A5_A5A5, 1'b0, 32'h0,          3, 1};
        vecs[8] = '{1'b0, 32'h0000_417C, 32'h0,         1'b0, 32'hA5A5_A5A5, 3, 0};
        vecs[9] = '{1'b1, 32'h8000_4108, 32'h7777_7777, 1'b1, 32'h0,          1, 0};

        reset = 1'b1;
        wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        core_idle = 1'b1;
        slv_address = 32'd0; slv_write_data = 32'd0; slv_mode = 2'b00; slv_select_regs = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_slv_ready", {31'd0, slv_ready}, 32'd0);
        chk("rst_slv_error", {31'd0, slv_error}, 32'd0);
        chk("rst_slv_read_data", slv_read_data, 32'd0);
        chk("rst_rf_cs", {31'd0, rf_cs_reg_write}, 32'd0);
        chk("rst_rf_read_reg", {27'd0, rf_read_reg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle passthrough of core writeback
        @(negedge clk);
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h0000_9999;
        #1;
        chk("pass_cs", {31'd0, rf_cs_reg_write}, 32'd1);
        chk("pass_reg", {27'd0, rf_write_reg}, 32'd9);
        chk("pass_data", rf_write_data, 32'h0000_9999);
        @(negedge clk);
        wb_valid = 1'b0;
        chk("pass_landed", regs[9], 32'h0000_9999);

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("x5_value", regs[5], 32'hDEAD_BEEF);

        // Drain timeout with the core never going idle
        core_idle = 1'b0;
        tv = '{1'b1, 32'h0000_4120, 32'h0000_00AA, 1'b1, 32'h0, 256, 0};
        run_vec(tv);
        core_idle = 1'b1;
        chk("timeout_no_write", regs[8], 32'd0);

        // Core writeback during DRAIN lands, then debug write completes
        core_idle = 1'b0;
        start_access(1'b1, 32'h0000_411C, 32'h0000_0011);
        @(posedge clk);
        #1;
        chk("drain_stall", {31'd0, core_stall}, 32'd1);
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0033;
        #1;
        chk("drain_pass_cs", {31'd0, rf_cs_reg_write}, 32'd1);
        chk("drain_pass_reg", {27'd0, rf_write_reg}, 32'd3);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        core_idle = 1'b1;
        wait_ready(n, st);
        chk("drain_err", {31'd0, slv_error}, 32'd0);
        chk("drain_core_write", regs[3], 32'h0000_0033);
        chk("drain_debug_write", regs[7], 32'h0000_0011);
        $display("drain sequence: x3=%h x7=%h err=%0b", regs[3], regs[7], slv_error);

        // Select held high after RESPOND: no re-access until it drops
        w0 = wr_count;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            bad |= slv_ready | core_stall;
        end
        chk("hold_select_idle", {31'd0, bad}, 32'd0);
        chk("hold_select_writes", wr_count - w0, 32'd0);
        $display("select held high: spurious activity=%0b", bad);

        // RV32E instance rejects x16; full instance accepts it
        tv = '{1'b0, 32'h0000_4140, 32'h0, 1'b0, 32'h0, 3, 0};
        run_vec(tv);
        chk("rv32e_error", {31'd0, d16_slv_error}, 32'd1);
        chk("rv32e_no_stall", {31'd0, d16_core_stall}, 32'd0);

        // Modes 00 and 11 ignored; arming survives them
        @(negedge clk);
        slv_select_regs = 1'b0;
        @(negedge clk);
        slv_select_regs = 1'b1;
        slv_address = 32'h0000_4118;
        slv_write_data = 32'h0000_6666;
        slv_mode = 2'b11;
        bad = 1'b0;
        repeat (4) begin @(posedge clk); #1; bad |= slv_ready | core_stall; end
        slv_mode = 2'b00;
        repeat (4) begin @(posedge clk); #1; bad |= slv_ready | core_stall; end
        chk("mode_ignored", {31'd0, bad}, 32'd0);
        slv_mode = 2'b10;
        wait_ready(n, st);
        chk("mode_then_write_lat", n, 32'd3);
        @(posedge clk);
        #1;
        chk("mode_then_write_x6", regs[6], 32'h0000_6666);
        $display("mode 00/11 ignored: activity=%0b, then write lat=%0d", bad, n);

        // Reset pulsed during DRAIN abandons the access
        core_idle = 1'b0;
        start_access(1'b1, 32'h0000_4128, 32'hCAFE_0001);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_stall", {31'd0, core_stall}, 32'd1);
        w0 = wr_count;
        @(negedge clk);
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h0000_0044;
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, core_stall}, 32'd0);
        chk("mid_rst_ready", {31'd0, slv_ready}, 32'd0);
        chk("mid_rst_error", {31'd0, slv_error}, 32'd0);
        chk("mid_rst_rdata", slv_read_data, 32'd0);
        chk("mid_rst_rf_cs", {31'd0, rf_cs_reg_write}, 32'd0);
        chk("mid_rst_read_reg", {27'd0, rf_read_reg}, 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        reset = 1'b1;
        core_idle = 1'b1;
        bad = 1'b0;
        repeat (6) begin @(posedge clk); #1; bad |= slv_ready | core_stall; end
        chk("post_rst_quiet", {31'd0, bad}, 32'd0);
        chk("post_rst_writes", wr_count - w0, 32'd0);
        chk("post_rst_x10", regs[10], 32'd0);
        $display("reset during drain: writes after reset=%0d x10=%h", wr_count - w0, regs[10]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
